// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: segment patterns,
// digit positions and the anode mask helper.
package seg7_pkg;

   localparam int SEG_W = 7;

   typedef logic [SEG_W-1:0] seg_t;
   typedef logic [1:0]       digit_idx_t;
   typedef logic [3:0]       bcd_t;
   typedef logic [3:0]       anode_t;

   // Patterns are {g,f,e,d,c,b,a} for a common-anode display (0 = segment lit)
   localparam seg_t SEG_0     = 7'b1000000;
   localparam seg_t SEG_1     = 7'b1111001;
   localparam seg_t SEG_2     = 7'b0100100;
   localparam seg_t SEG_3     = 7'b0110000;
   localparam seg_t SEG_4     = 7'b0011001;
   localparam seg_t SEG_5     = 7'b0010010;
   localparam seg_t SEG_6     = 7'b0000010;
   localparam seg_t SEG_7     = 7'b1111000;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0010000;
   localparam seg_t SEG_BLANK = 7'b1111111;

   localparam digit_idx_t DIG_HU = 2'd0;
   localparam digit_idx_t DIG_HL = 2'd1;
   localparam digit_idx_t DIG_MU = 2'd2;
   localparam digit_idx_t DIG_ML = 2'd3;

   localparam anode_t AN_OFF = 4'hF;

   // Digit 0 sits on an[3] (leftmost), so the active-low enable walks right
   function automatic anode_t anodeFor(input digit_idx_t idx);
      return ~(4'b1000 >> idx);
   endfunction

endpackage

// File: rtl/seg7_display_mux_if.sv
// Bundle between the timekeeper (master) and the display multiplexer (slave):
// digit values and mode flags in, raw segment/anode/dp drive out.
interface seg7_display_mux_if;
   import seg7_pkg::*;

   logic       setup_mode;
   logic [1:0] loc;
   bcd_t       hour_upper;
   bcd_t       hour_lower;
   bcd_t       minute_upper;
   bcd_t       minute_lower;
   logic [5:0] second_counter;

   seg_t       seg;
   anode_t     an;
   logic       dp;

   modport master (
      output setup_mode, loc, hour_upper, hour_lower,
             minute_upper, minute_lower, second_counter,
      input  seg, an, dp
   );

   modport slave (
      input  setup_mode, loc, hour_upper, hour_lower,
             minute_upper, minute_lower, second_counter,
      output seg, an, dp
   );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9
// produce a dark digit rather than a garbage glyph.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  bcd_t bcd_i,
   output seg_t seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_display_mux.sv
// Time-multiplexed 4-digit driver: scans digits at the refresh rate, blinks
// the digit under edit in setup mode and drives the colon on digit 1.
module seg7_display_mux
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 49999,
   parameter int BLINK_DIV   = 24999999
)(
   input  logic               clk,
   input  logic               rst_n,
   seg7_display_mux_if.slave  bus
);

   localparam int REF_W = (REFRESH_DIV > 0) ? $clog2(REFRESH_DIV + 1) : 1;
   localparam int BLK_W = (BLINK_DIV   > 0) ? $clog2(BLINK_DIV   + 1) : 1;

   localparam logic [REF_W-1:0] REF_TERM = REF_W'(REFRESH_DIV);
   localparam logic [BLK_W-1:0] BLK_TERM = BLK_W'(BLINK_DIV);

   logic [REF_W-1:0] refreshCnt_q, refreshCnt_d;
   logic [BLK_W-1:0] blinkCnt_q,   blinkCnt_d;
   digit_idx_t       digitIdx_q,   digitIdx_d;
   logic             blinkPhase_q, blinkPhase_d;

   seg_t             seg_q, seg_d;
   anode_t           an_q,  an_d;
   logic             dp_q,  dp_d;

   bcd_t             selDigit;
   seg_t             decodedSeg;
   logic             refreshWrap;
   logic             blinkWrap;
   logic             blankNow;

   // Scan and blink timebases: both free-running, independent of mode
   always_comb begin
      refreshWrap  = (refreshCnt_q == REF_TERM);
      refreshCnt_d = refreshWrap ? '0 : refreshCnt_q + 1'b1;
      digitIdx_d   = refreshWrap ? digitIdx_q + 2'd1 : digitIdx_q;

      blinkWrap    = (blinkCnt_q == BLK_TERM);
      blinkCnt_d   = blinkWrap ? '0 : blinkCnt_q + 1'b1;
      blinkPhase_d = blinkWrap ? ~blinkPhase_q : blinkPhase_q;
   end

   always_comb begin
      selDigit = bus.hour_upper;
      case (digitIdx_q)
         DIG_HU:  selDigit = bus.hour_upper;
         DIG_HL:  selDigit = bus.hour_lower;
         DIG_MU:  selDigit = bus.minute_upper;
         DIG_ML:  selDigit = bus.minute_lower;
         default: selDigit = bus.hour_upper;
      endcase
   end

   bcd_to_seg7 u_decode (
      .bcd_i (selDigit),
      .seg_o (decodedSeg)
   );

   // Outputs are computed from the current digit index so that seg and an
   // land on the same edge; blanking only darkens segments, the anode stays on
   always_comb begin
      blankNow = bus.setup_mode && blinkPhase_q && (digitIdx_q == bus.loc);
      seg_d    = blankNow ? SEG_BLANK : decodedSeg;
      an_d     = anodeFor(digitIdx_q);
      dp_d     = 1'b1;
      if (digitIdx_q == DIG_HL) begin
         dp_d = bus.setup_mode ? 1'b0 : ~bus.second_counter[0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         refreshCnt_q <= '0;
         digitIdx_q   <= DIG_HU;
         blinkCnt_q   <= '0;
         blinkPhase_q <= 1'b0;
         seg_q        <= SEG_BLANK;
         an_q         <= AN_OFF;
         dp_q         <= 1'b1;
      end else begin
         refreshCnt_q <= refreshCnt_d;
         digitIdx_q   <= digitIdx_d;
         blinkCnt_q   <= blinkCnt_d;
         blinkPhase_q <= blinkPhase_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         dp_q         <= dp_d;
      end
   end

   assign bus.seg = seg_q;
   assign bus.an  = an_q;
   assign bus.dp  = dp_q;

endmodule

// File: doc/seg7_display_mux.md
Name: seg7_display_mux

Overview:
- Time-multiplexed 4-digit seven-segment driver.
- Sits directly downstream of the digital clock timekeeper. Consumes its four BCD digits, seconds count, setup-mode flag and setup digit location.
- Drives the board's common-anode display: segments, anodes and decimal point.
- In setup mode, blinks the digit currently being edited.

Parameters:
REFRESH_DIV, 49999, refresh counter terminal value; each digit is lit for REFRESH_DIV+1 clk cycles (1 ms at 50 MHz).
BLINK_DIV, 24999999, blink counter terminal value; blink phase toggles every BLINK_DIV+1 cycles (0.5 s).

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  synchronous active-low reset
setup_mode  input  1  1 = timekeeper is in time-setup mode
loc  input  2  digit under edit: 0=hour upper, 1=hour lower, 2=minute upper, 3=minute lower
hour_upper  input  4  BCD digit 0
hour_lower  input  4  BCD digit 1
minute_upper  input  4  BCD digit 2
minute_lower  input  4  BCD digit 3
second_counter  input  6  seconds count, used only for colon blink
seg  output  7  {g,f,e,d,c,b,a}, active-low
an  output  4  anode enables, active-low; an[3] is the leftmost digit (digit 0)
dp  output  1  decimal point, active-low

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (rst_n). All state updates on posedge clk.
- While rst_n=0 at an edge, all of the following are forced: seg=7'h7F, an=4'hF, dp=1, refresh_cnt=0, digit_idx=0, blink_cnt=0, blink_phase=0.
- Refresh counter:
  - refresh_cnt counts 0..REFRESH_DIV.
  - At REFRESH_DIV it returns to 0 and digit_idx (2 bit) increments, wrapping 3->0.
- Blink counter:
  - blink_cnt counts 0..BLINK_DIV.
  - At BLINK_DIV it returns to 0 and blink_phase toggles.
  - The counter runs regardless of setup_mode.
- Digit select: digit_idx d selects the source digit (0 hour_upper, 1 hour_lower, 2 minute_upper, 3 minute_lower). an = ~(4'b1000 >> d).
- Segment decode, per digit value:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = 1111111 (blank)
- Blanking: if setup_mode=1 and blink_phase=1 and d==loc, seg=7'h7F. The anode stays asserted.
- Decimal point: dp is driven only on d==1 (the colon position):
  - run mode: dp = ~second_counter[0];
  - setup mode: dp = 0 (lit).
  - For all other d, dp = 1.
- Latency:
  - seg, an and dp are registered.
  - They reflect digit_idx and input values sampled at the previous edge, i.e. 1 cycle of latency.
  - an and seg always change on the same edge, so there is no cross-digit glitch.
- Boundary conditions:
  - setup_mode falling mid-blink: blanking stops on the next output update; blink_cnt is not reset.
  - loc changing mid-scan: takes effect on the next output update.
  - Input digits changing while displayed: the new value appears 1 cycle later; no hold is required.
  - rst_n asserted mid-scan: the reset values above apply at that edge. After release, the first output update shows digit 0 (an=4'b0111).
- No handshake: inputs are level-sampled every cycle and are in the same clock domain.

Decomposition:
- Shared package seg7_pkg holds:
  - the SEG_0..SEG_9 and SEG_BLANK constants;
  - digit index constants DIG_HU=0, DIG_HL=1, DIG_MU=2, DIG_ML=3;
  - the segment bus width of 7.
- One combinational sub-module, bcd_to_seg7: 4-bit BCD in, 7-bit active-low segments out, blank for values >9. The muxing, counters and blink logic stay in seg7_display_mux.

Test Plan:
All scenarios run with REFRESH_DIV=3 and BLINK_DIV=15.
1. Reset hold then release, digits 1,2,3,4, setup_mode=0.
   - During reset: seg=7F, an=F, dp=1.
   - First edge after release: an=0111, seg=1111001.
   - Every 4 cycles the output advances through an=1011/0100100, an=1101/0110000, an=1110/0011001, then wraps to an=0111.
2. Digit value 4'hA on minute_lower -> when an=1110, seg=1111111.
3. setup_mode=1, loc=2, minute_upper=5:
   - While blink_phase=0, an=1101 shows seg=0010010.
   - After 16 cycles (blink_phase=1), an=1101 shows seg=1111111; digits 0, 1 and 3 remain unblanked.
4. Colon: setup_mode=0.
   - second_counter=6'd7 -> dp=0 only while an=1011.
   - second_counter=6'd8 -> dp=1 for all digits.
   - setup_mode=1 -> dp=0 while an=1011 regardless of second_counter.
5. Reset mid-scan with digit_idx=2 -> at the reset edge: seg=7F, an=F. After release, scanning restarts at an=0111.
6. Change hour_lower from 3 to 9 while an=1011 is displayed -> seg goes from 0110000 to 0010000 exactly one cycle after the input change.
